logic_op_arbiter: RTL and testbench
===================================

Name: logic_op_arbiter

Overview:
- Shares one bitwise logic unit (AND/OR/XOR/NAND/NOR/XNOR/NOT) among N_REQ requesters.
- Each requester presents operands and an opcode under a valid/ready handshake.
- A round-robin arbiter picks one request per cycle. The result is registered into a single-entry output slot, tagged with the requester index.
- Sits between client blocks and the shared combinational gate datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- ID_W, 2, width of requester index; must equal clog2(N_REQ)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  N_REQ  per-requester request valid
- req_ready  output  N_REQ  per-requester accept; one-hot or zero
- req_a  input  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  input  N_REQ*WIDTH  operand B, same packing
- req_op  input  N_REQ*3  opcode, requester i at [i*3 +: 3]
- rsp_valid  output  1  result slot holds a valid result
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  WIDTH  registered result
- rsp_id  output  ID_W  index of requester that produced rsp_data
- busy  output  1  high while any req_valid is high or rsp_valid is high

Behaviour:
- Clocking: single clock clk. rst is asynchronous, active-high; all flops clear immediately on rst assertion.
- Reset values:
  - rsp_valid=0, rsp_data=0, rsp_id=0
  - rr_ptr=0 (highest-priority index)
  - state=EMPTY
  - req_ready=0 while rst is high
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT_A, 7 NOT_B. All are bitwise over WIDTH bits; no carries, no width growth.
- FSM states:
  - EMPTY: slot free.
  - FULL: slot holds an unconsumed result.
- can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- Arbitration (combinational, same cycle):
  - Search req_valid starting at rr_ptr, wrapping modulo N_REQ; first set bit is the grant g.
  - If can_accept and any req_valid: req_ready[g]=1, all other bits 0. Otherwise req_ready=0.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
- Transfer on req_valid[g] & req_ready[g]:
  - Next edge: rsp_data <= op(req_a[g], req_b[g], req_op[g]), rsp_id <= g, rsp_valid <= 1, rr_ptr <= (g+1) mod N_REQ, state <= FULL.
  - Latency: result visible one cycle after the accepting edge.
- Drain: rsp_valid & rsp_ready with no new transfer -> rsp_valid <= 0, state <= EMPTY. rsp_data/rsp_id hold their last values.
- Simultaneous drain and accept in FULL: slot is overwritten with the new result and rsp_valid stays 1. Full throughput is 1 op/cycle.
- Backpressure: in FULL with rsp_ready=0, req_ready=0 and rsp_data/rsp_id/rsp_valid are held stable.
- No requests: rr_ptr is unchanged.
- Fairness: any continuously asserted requester is granted within N_REQ transfers.
- Wrap-around: grant at index N_REQ-1 sets rr_ptr to 0.
- Reset mid-operation: any pending result is discarded; no response is emitted for it after rst deasserts.

Decomposition:
- Shared include logic_ops_pkg:
  - opcode localparams OP_AND..OP_NOT_B (3-bit)
  - state encodings S_EMPTY=1'b0, S_FULL=1'b1
- Sub-module logic_unit (purely combinational):
  - inputs a[WIDTH], b[WIDTH], op[3]; output y[WIDTH]
  - implements the 8 opcodes
  - reused by other blocks needing the gate datapath
- Round-robin search stays inline in logic_op_arbiter.

Test Plan:
1. Reset: assert rst mid-cycle with slot FULL -> rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0 immediately, without waiting for a clock edge.
2. Single op: req_valid=4'b0001, a=8'hF0, b=8'h3C, op=2 (XOR), rsp_ready=1 -> req_ready=4'b0001 that cycle; next cycle rsp_valid=1, rsp_data=8'hCC, rsp_id=0.
3. Round-robin: all four valid every cycle, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 on consecutive cycles, rsp_valid continuously 1.
4. Backpressure: slot FULL, rsp_ready=0 for 3 cycles with req_valid=4'b0100 -> req_ready=0 and rsp_data/rsp_id stable. Raise rsp_ready -> same-cycle accept of requester 2, new result next cycle.
5. Opcodes: a=8'hA5, b=8'h0F, op 0..7 -> 05, AF, AA, FA, 50, 55, 5A, F0.
6. Wrap/skip: rr_ptr=3, req_valid=4'b0110 -> grant 1, rr_ptr becomes 2. Next, req_valid=4'b0010 alone -> grant 1 again.

Source files
------------

// File: rtl/logic_ops_pkg.sv
// logic_ops_pkg: opcode and slot-state encodings shared by the gate datapath and its arbiter
package logic_ops_pkg;
  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NAND  = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_NOT_A = 3'd6;
  localparam logic [2:0] OP_NOT_B = 3'd7;
  localparam logic [0:0] S_EMPTY  = 1'b0;
  localparam logic [0:0] S_FULL   = 1'b1;
endpackage

// File: rtl/logic_unit.sv
// logic_unit: combinational bitwise gate datapath; ports a, b, op in, y out
module logic_unit
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_NOT_A: y = ~a;
      default:  y = ~b;
    endcase
  end
endmodule

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin share of one logic_unit; ports clk/rst, req_* handshake in, rsp_* slot out, busy
module logic_op_arbiter
  import logic_ops_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*3-1:0]     req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);
  logic [0:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic [WIDTH-1:0] y;
  logic            can_accept;
  logic            xfer;
  assign rsp_valid  = (state == S_FULL);
  assign can_accept = (state == S_EMPTY) | (rsp_valid & rsp_ready);
  // Scan from the farthest offset down so the first valid at or after rr_ptr wins.
  always_comb begin
    grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr) + k) % N_REQ]) grant = ID_W'((int'(rr_ptr) + k) % N_REQ);
  end
  assign req_ready = (!rst && can_accept && |req_valid) ? N_REQ'(1) << grant : '0;
  assign xfer      = |(req_valid & req_ready);
  assign busy      = |req_valid | rsp_valid;
  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .a  (req_a[int'(grant)*WIDTH +: WIDTH]),
    .b  (req_b[int'(grant)*WIDTH +: WIDTH]),
    .op (req_op[int'(grant)*3 +: 3]),
    .y  (y)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_EMPTY;
      rr_ptr   <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (xfer) begin
      state    <= S_FULL;
      rsp_data <= y;
      rsp_id   <= grant;
      rr_ptr   <= (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      state <= S_EMPTY;
    end
  end
endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: directed-vector bench for logic_op_arbiter
module tb_logic_op_arbiter;
  logic        clk = 0;
  logic        rst = 1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [11:0] req_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 0;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  op_exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hF0};
  logic [7:0]  rr_a   [4] = '{8'h5A, 8'h11, 8'h22, 8'h33};
  logic_op_arbiter #(.N_REQ(4), .WIDTH(8), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_op[i*3 +: 3] = op;
  endtask
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  initial begin
    req_valid = 4'b1111;
    step();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_data", 32'(rsp_data), 32'h0);
    check("rst_id", 32'(rsp_id), 32'h0);
    rst = 0;
    req_valid = 4'b0001;
    set_req(0, 8'hF0, 8'h3C, 3'd2);
    rsp_ready = 1;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    step();
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_data", 32'(rsp_data), 32'hCC);
    check("single_id", 32'(rsp_id), 32'h0);
    for (int k = 0; k < 8; k++) begin
      set_req(0, 8'hA5, 8'h0F, 3'(k));
      step();
      check($sformatf("op%0d_data", k), 32'(rsp_data), 32'(op_exp[k]));
      check($sformatf("op%0d_valid", k), 32'(rsp_valid), 32'h1);
    end
    req_valid = 4'b1111;
    rsp_ready = 0;
    #2;
    rst = 1;
    #1;
    check("arst_valid", 32'(rsp_valid), 32'h0);
    check("arst_data", 32'(rsp_data), 32'h0);
    check("arst_id", 32'(rsp_id), 32'h0);
    check("arst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 0;
    req_valid = 4'b0000;
    step();
    check("arst_discard", 32'(rsp_valid), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) set_req(i, rr_a[i], 8'h00, 3'd1);
    req_valid = 4'b1111;
    rsp_ready = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("rr%0d_valid", c), 32'(rsp_valid), 32'h1);
      check($sformatf("rr%0d_id", c), 32'(rsp_id), 32'(c % 4));
      check($sformatf("rr%0d_data", c), 32'(rsp_data), 32'(rr_a[c % 4]));
    end
    rsp_ready = 0;
    req_valid = 4'b0100;
    set_req(2, 8'hC3, 8'h0F, 3'd0);
    #1;
    check("bp_ready0", 32'(req_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'h0);
      check($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'h1);
      check($sformatf("bp%0d_data", c), 32'(rsp_data), 32'h5A);
      check($sformatf("bp%0d_id", c), 32'(rsp_id), 32'h0);
      check($sformatf("bp%0d_busy", c), 32'(busy), 32'h1);
    end
    rsp_ready = 1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'b0100);
    step();
    check("bp_new_data", 32'(rsp_data), 32'h03);
    check("bp_new_id", 32'(rsp_id), 32'h2);
    req_valid = 4'b0110;
    #1;
    check("wrap_ready", 32'(req_ready), 32'b0010);
    step();
    check("wrap_id", 32'(rsp_id), 32'h1);
    check("wrap_data", 32'(rsp_data), 32'h11);
    req_valid = 4'b0010;
    #1;
    check("skip_ready", 32'(req_ready), 32'b0010);
    step();
    check("skip_id", 32'(rsp_id), 32'h1);
    check("skip_valid", 32'(rsp_valid), 32'h1);
    req_valid = 4'b0000;
    step();
    check("drain_valid", 32'(rsp_valid), 32'h0);
    check("drain_data_hold", 32'(rsp_data), 32'h11);
    check("drain_id_hold", 32'(rsp_id), 32'h1);
    check("drain_busy", 32'(busy), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
